// File: rtl/mantissa_divsqrt.sv
// Iterative mantissa divider / square-root unit: restoring radix-2 recurrences,
// one result bit per cycle, followed by a single normalise-and-round cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; done pulses here after a completed op
// S_ITER  | one quotient/root bit per cycle until counter hits zero
// S_ROUND | normalise, round, and register results
module mantissa_divsqrt #(
  parameter int WIDTH  = 23,
  parameter int GUARDS = 3,
  parameter int QW     = WIDTH + GUARDS + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             shift,
  input  logic             sign,
  input  logic [1:0]       round_mode,
  input  logic [WIDTH-1:0] m1,
  input  logic [WIDTH-1:0] m2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] m3,
  output logic             decrement_exponent,
  output logic             increment_exponent,
  output logic             inexact
);

  localparam int RW = QW + 2;        // partial remainder width
  localparam int SW = 2 * QW - 2;    // radicand width (two bits consumed per root bit)
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_ROUND = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]  cnt;
  logic           op_q;
  logic           sign_q;
  logic [1:0]     mode_q;
  logic [WIDTH:0] div_q;
  logic [RW-1:0]  rem_q;
  logic [SW-1:0]  rad_q;
  logic [QW-1:0]  q_q;

  logic           accept;
  logic           last_iter;

  assign accept    = (state == S_IDLE) && start;
  assign last_iter = (cnt == '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start)     state_next = S_ITER;
      S_ITER:  if (last_iter) state_next = S_ROUND;
      S_ROUND:                state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // ---------------------------------------------------------------- recurrence step
  logic [RW-1:0] div_ext;
  logic          div_ge;
  logic [RW-1:0] sq_rem_sh;
  logic [RW-1:0] sq_trial;
  logic          sq_ge;
  logic          bit_next;
  logic [RW-1:0] rem_next;

  always_comb begin
    div_ext   = {{(RW-WIDTH-1){1'b0}}, div_q};
    div_ge    = (rem_q >= div_ext);
    // root step: bring down the next radicand bit pair, trial subtract 4*root+1
    sq_rem_sh = {rem_q[RW-3:0], rad_q[SW-1 -: 2]};
    sq_trial  = {q_q, 2'b01};
    sq_ge     = (sq_rem_sh >= sq_trial);
    bit_next  = 1'b0;
    rem_next  = '0;
    if (op_q) begin
      bit_next = sq_ge;
      rem_next = sq_ge ? (sq_rem_sh - sq_trial) : sq_rem_sh;
    end else begin
      bit_next = div_ge;
      rem_next = (div_ge ? (rem_q - div_ext) : rem_q) << 1;
    end
  end

  // ---------------------------------------------------------------- normalise and round
  logic [QW-2:0]  norm;
  logic           hi_drop;
  logic           dec_next;
  logic [WIDTH:0] sig;
  logic           guard_bit;
  logic           sticky;
  logic           inx_next;
  logic           round_up;
  logic [WIDTH:0] frac_sum;
  logic           carry;
  logic [WIDTH-1:0] m3_next;

  always_comb begin
    norm     = q_q[QW-2:0];
    hi_drop  = 1'b0;
    dec_next = 1'b0;
    if (!op_q && q_q[QW-1]) begin
      norm    = q_q[QW-1:1];
      hi_drop = q_q[0];
    end else if (!op_q) begin
      dec_next = 1'b1;
    end

    sig       = norm[QW-2:GUARDS];
    guard_bit = norm[GUARDS-1];
    sticky    = (|norm[GUARDS-2:0]) | hi_drop | (rem_q != '0);
    inx_next  = guard_bit | sticky;

    case (mode_q)
      2'b00:   round_up = guard_bit & (sticky | sig[0]);
      2'b01:   round_up = 1'b0;
      2'b10:   round_up = ~sign_q & inx_next;
      default: round_up =  sign_q & inx_next;
    endcase

    // the hidden bit is always set, so a carry into it means 10.000...
    frac_sum = {1'b0, sig[WIDTH-1:0]} + {{WIDTH{1'b0}}, round_up};
    carry    = frac_sum[WIDTH] & sig[WIDTH];
    m3_next  = carry ? '0 : frac_sum[WIDTH-1:0];
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt                <= '0;
      op_q               <= 1'b0;
      sign_q             <= 1'b0;
      mode_q             <= 2'b00;
      div_q              <= '0;
      rem_q              <= '0;
      rad_q              <= '0;
      q_q                <= '0;
      done               <= 1'b0;
      m3                 <= '0;
      decrement_exponent <= 1'b0;
      increment_exponent <= 1'b0;
      inexact            <= 1'b0;
    end else begin
      done <= (state == S_ROUND);
      if (accept) begin
        op_q   <= op;
        sign_q <= sign;
        mode_q <= round_mode;
        div_q  <= {1'b1, m2};
        q_q    <= '0;
        cnt    <= op ? CW'(QW - 2) : CW'(QW - 1);
        rem_q  <= op ? '0 : {{(RW-WIDTH-1){1'b0}}, 1'b1, m1};
        // odd exponent: radicand doubled, i.e. positioned one bit higher
        rad_q  <= shift ? {1'b1, m1, {(SW-WIDTH-1){1'b0}}}
                        : {1'b0, 1'b1, m1, {(SW-WIDTH-2){1'b0}}};
      end else if (state == S_ITER) begin
        q_q   <= {q_q[QW-2:0], bit_next};
        rem_q <= rem_next;
        rad_q <= rad_q << 2;
        cnt   <= cnt - CW'(1);
      end else if (state == S_ROUND) begin
        m3                 <= m3_next;
        decrement_exponent <= dec_next;
        increment_exponent <= carry;
        inexact            <= inx_next;
      end
    end
  end

endmodule
